ram_arbiter: RTL

- Shares one single-port synchronous block RAM between two requesters: A (CPU side) and B (video/DMA side).
- The RAM has a one-cycle read latency and registers its output when its enable is high.
- The block issues at most one RAM access per cycle, chosen by round-robin priority.
- It returns read data to the requester that issued the read, tagged with a valid strobe.
- It supports a lock that keeps ownership with one requester for read-modify-write sequences.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 27 ++
 rtl/ram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter.
// Requester IDs and the lock-owner encoding.
package ram_arb_pkg;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_A    = 2'b01,
      OWN_B    = 2'b10
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with lock override.
// req[1:0], last_grant, lock_owner in; one-hot grant[1:0] out.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] lock_owner,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (lock_owner == OWN_A && req[0]) begin
         grant = 2'b01;
      end else if (lock_owner == OWN_B && req[1]) begin
         grant = 2'b10;
      end else if (req == 2'b01) begin
         grant = 2'b01;
      end else if (req == 2'b10) begin
         grant = 2'b10;
      end else if (req == 2'b11) begin
         grant = (last_grant == REQ_B) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port sync RAM between requesters A and B.
// Ports: A/B req/we/lock/addr/din -> ack/rvalid/rdata; ram_* to the RAM.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_BITS = 10,
   parameter int DATA_BITS = 8,
   parameter int LOCK_MAX  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_req,
   input  logic                 a_we,
   input  logic                 a_lock,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [DATA_BITS-1:0] a_din,
   output logic                 a_ack,
   output logic                 a_rvalid,
   output logic [DATA_BITS-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic                 b_lock,
   input  logic [ADDR_BITS-1:0] b_addr,
   input  logic [DATA_BITS-1:0] b_din,
   output logic                 b_ack,
   output logic                 b_rvalid,
   output logic [DATA_BITS-1:0] b_rdata,
   output logic                 ram_ena,
   output logic                 ram_wea,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [DATA_BITS-1:0] ram_din,
   input  logic [DATA_BITS-1:0] ram_dout
);

   logic       last_grant;
   logic [1:0] lock_owner;
   logic [3:0] lock_cnt;
   logic       rd_pend;
   logic       rd_tag;

   logic [1:0] arb_grant;
   logic [1:0] grant;
   logic       g_any;
   logic       g_id;
   logic       g_we;
   logic       g_lock;
   logic       owner_drop;
   logic       owner_id;

   logic       last_nx;
   logic [1:0] own_nx;
   logic [3:0] cnt_nx;

   rr_arb2 u_arb (
      .req        ({b_req, a_req}),
      .last_grant (last_grant),
      .lock_owner (lock_owner),
      .grant      (arb_grant)
   );

   // No access may reach the RAM while reset is held.
   assign grant  = rst_n ? arb_grant : 2'b00;
   assign a_ack  = grant[0];
   assign b_ack  = grant[1];
   assign g_any  = |grant;
   assign g_id   = grant[1];
   assign g_we   = g_id ? b_we : a_we;
   assign g_lock = g_id ? b_lock : a_lock;

   assign ram_ena  = g_any;
   assign ram_wea  = g_any & g_we;
   assign ram_addr = g_id ? b_addr : a_addr;
   assign ram_din  = g_id ? b_din : a_din;

   assign owner_id   = (lock_owner == OWN_B);
   assign owner_drop = (lock_owner == OWN_A && !a_req) ||
                       (lock_owner == OWN_B && !b_req);

   // Owner dropping req releases first; the winner may then relock.
   always_comb begin
      own_nx  = lock_owner;
      cnt_nx  = lock_cnt;
      last_nx = g_any ? g_id : last_grant;
      if (owner_drop) begin
         own_nx  = OWN_NONE;
         cnt_nx  = 4'd0;
         last_nx = owner_id;
      end
      if (g_any) begin
         if (g_lock) begin
            cnt_nx = (own_nx == OWN_NONE) ? 4'd1 : 4'(lock_cnt + 4'd1);
            own_nx = g_id ? OWN_B : OWN_A;
            if (cnt_nx >= 4'(LOCK_MAX)) begin
               own_nx  = OWN_NONE;
               cnt_nx  = 4'd0;
               last_nx = g_id;
            end
         end else if (own_nx != OWN_NONE) begin
            own_nx  = OWN_NONE;
            cnt_nx  = 4'd0;
            last_nx = g_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= REQ_B;
         lock_owner <= OWN_NONE;
         lock_cnt   <= 4'd0;
         rd_pend    <= 1'b0;
         rd_tag     <= REQ_A;
         a_rvalid   <= 1'b0;
         b_rvalid   <= 1'b0;
         a_rdata    <= '0;
         b_rdata    <= '0;
      end else begin
         last_grant <= last_nx;
         lock_owner <= own_nx;
         lock_cnt   <= cnt_nx;
         rd_pend    <= g_any & ~g_we;
         if (g_any) begin
            rd_tag <= g_id;
         end
         // RAM output is only valid for one cycle; hold it here.
         a_rvalid <= rd_pend & (rd_tag == REQ_A);
         b_rvalid <= rd_pend & (rd_tag == REQ_B);
         if (rd_pend && rd_tag == REQ_A) begin
            a_rdata <= ram_dout;
         end
         if (rd_pend && rd_tag == REQ_B) begin
            b_rdata <= ram_dout;
         end
      end
   end

endmodule
